// File: rtl/flash_ctrl_if.sv
// Host request/response and flash strobe/data bundle for flash_ctrl.
// slave = controller side, master = host plus flash device side.
interface flash_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        fl_rd_en;
  logic        fl_wr_en;
  logic        fl_erase_en;
  logic [11:0] fl_addr;
  logic [31:0] fl_idata;
  logic [31:0] fl_odata;
  logic        fl_busy;
  logic        fl_error;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, fl_odata, fl_busy, fl_error,
    output req_ready, resp_valid, resp_rdata, resp_err,
           fl_rd_en, fl_wr_en, fl_erase_en, fl_addr, fl_idata
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, fl_odata, fl_busy, fl_error,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           fl_rd_en, fl_wr_en, fl_erase_en, fl_addr, fl_idata
  );
endinterface

// File: rtl/flash_ctrl.sv
// Single-outstanding flash controller: read / program(+verify) / erase with timeout.
// Read latency handshake->resp_valid = WAIT_CYCLES+2 at fl_busy=0; one request at a time, response is never stalled.
module flash_ctrl #(
  parameter int unsigned WAIT_CYCLES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  flash_ctrl_if.slave io_if
);
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_VRD_ISSUE, S_VRD_WAIT, S_RESP
  } state_t;

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_PROG_VFY = 2'b01;
  localparam logic [1:0] OP_ERASE    = 2'b10;
  localparam logic [1:0] OP_PROG     = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_FLASH   = 2'b01;
  localparam logic [1:0] ERR_VERIFY  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] DONE_CNT = 8'(WAIT_CYCLES - 1);
  localparam logic [7:0] TMO_CNT  = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_sticky;
  logic [1:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_idata;
  logic        r_rd_en;
  logic        r_wr_en;
  logic        r_erase_en;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_resp_err;

  logic        w_hs;
  logic        w_done;
  logic        w_tmo;
  logic        w_err;
  logic        w_fin;
  logic        w_to_vrd;
  logic [31:0] w_fin_rdata;
  logic [1:0]  w_fin_err;

  assign io_if.req_ready   = (r_state == S_IDLE) && !rst;
  assign io_if.resp_valid  = r_resp_valid;
  assign io_if.resp_rdata  = r_resp_rdata;
  assign io_if.resp_err    = r_resp_err;
  assign io_if.fl_rd_en    = r_rd_en;
  assign io_if.fl_wr_en    = r_wr_en;
  assign io_if.fl_erase_en = r_erase_en;
  assign io_if.fl_addr     = r_addr;
  assign io_if.fl_idata    = r_idata;

  assign w_hs   = io_if.req_valid && io_if.req_ready;
  assign w_done = (r_cnt >= DONE_CNT) && !io_if.fl_busy;
  assign w_tmo  = (r_cnt >= TMO_CNT);
  // An error flagged in the completing cycle counts as much as an earlier one.
  assign w_err  = r_sticky || io_if.fl_error;

  always_comb begin
    w_fin       = 1'b0;
    w_to_vrd    = 1'b0;
    w_fin_rdata = '0;
    w_fin_err   = ERR_OK;
    if ((r_state == S_WAIT) || (r_state == S_VRD_WAIT)) begin
      if (w_done) begin
        if (r_state == S_VRD_WAIT) begin
          w_fin       = 1'b1;
          w_fin_rdata = io_if.fl_odata;
          if (w_err) begin
            w_fin_err = ERR_FLASH;
          end else if (io_if.fl_odata != r_idata) begin
            w_fin_err = ERR_VERIFY;
          end
        end else if ((r_op == OP_PROG_VFY) && !w_err) begin
          w_to_vrd = 1'b1;
        end else begin
          w_fin       = 1'b1;
          w_fin_rdata = (r_op == OP_READ) ? io_if.fl_odata : 32'd0;
          w_fin_err   = w_err ? ERR_FLASH : ERR_OK;
        end
      end else if (w_tmo) begin
        w_fin     = 1'b1;
        w_fin_err = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sticky     <= 1'b0;
      r_op         <= OP_READ;
      r_addr       <= '0;
      r_idata      <= '0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_erase_en   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= ERR_OK;
    end else begin
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_erase_en   <= 1'b0;
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_op       <= io_if.req_op;
            r_addr     <= io_if.req_addr;
            r_idata    <= io_if.req_wdata;
            r_sticky   <= 1'b0;
            r_rd_en    <= (io_if.req_op == OP_READ);
            r_wr_en    <= (io_if.req_op == OP_PROG_VFY) || (io_if.req_op == OP_PROG);
            r_erase_en <= (io_if.req_op == OP_ERASE);
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT, S_VRD_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (io_if.fl_error) begin
            r_sticky <= 1'b1;
          end
          if (w_to_vrd) begin
            r_rd_en <= 1'b1;
            r_state <= S_VRD_ISSUE;
          end else if (w_fin) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_fin_rdata;
            r_resp_err   <= w_fin_err;
            r_state      <= S_RESP;
          end
        end
        S_VRD_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_VRD_WAIT;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/flash_ctrl.md
FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3, minimum WAIT-state cycles after a strobe before completion (legal 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, WAIT-state cycles with fl_busy high before abort (8-bit counter).
REQ-003 SHALL have a single clock `clk`; reset `rst` is synchronous and active-high.
REQ-004 clk  in  1  clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  host request present.
REQ-007 req_ready  out  1  controller accepts a request; transfer on valid&ready.
REQ-008 req_op  in  2  00 read, 01 program+verify, 10 erase, 11 program without verify.
REQ-009 req_addr  in  12  word address.
REQ-010 req_wdata  in  32  program data.
REQ-011 resp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-012 resp_rdata  out  32  read data / verify read-back / 0.
REQ-013 resp_err  out  2  00 OK, 01 FLASH_ERR, 10 VERIFY_FAIL, 11 TIMEOUT.
REQ-014 fl_rd_en, fl_wr_en, fl_erase_en  out  1 each  one-cycle flash strobes.
REQ-015 fl_addr  out  12; fl_idata  out  32  flash address/data, driven from latched request.
REQ-016 fl_odata  in  32; fl_busy  in  1; fl_error  in  1  flash responses.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT, VRD_ISSUE, VRD_WAIT, RESP.
REQ-018 req_ready SHALL be 1 only in IDLE with rst low; on handshake, op/addr/wdata latched, next state ISSUE.
REQ-019 ISSUE: exactly one strobe high for that cycle (rd for 00, wr for 01/11, erase for 10); counter cleared; next WAIT.
REQ-020 Strobes SHALL be mutually exclusive and never high for more than one consecutive cycle.
REQ-021 fl_addr/fl_idata SHALL hold latched values from ISSUE until the next handshake.
REQ-022 WAIT/VRD_WAIT: counter increments each cycle; any fl_error=1 sampled sets a sticky error flag.
REQ-023 Completion when counter >= WAIT_CYCLES-1 and fl_busy=0; WAIT_CYCLES cycles minimum.
REQ-024 If counter reaches TIMEOUT_CYCLES-1 without completion, next state RESP with resp_err=11.
REQ-025 Read completion: capture fl_odata into resp_rdata; next RESP.
REQ-026 Op 01 completion without sticky error: next VRD_ISSUE (fl_rd_en one cycle, same addr), then VRD_WAIT with counter cleared; sticky error not cleared.
REQ-027 VRD_WAIT completion: resp_rdata=fl_odata; mismatch with latched wdata gives VERIFY_FAIL.
REQ-028 Op 01 with sticky error after WAIT: skip verify, RESP with 01.
REQ-029 Erase and op 11: resp_rdata=0.
REQ-030 Error precedence: TIMEOUT > FLASH_ERR > VERIFY_FAIL > OK.
REQ-031 RESP: resp_valid=1 for exactly one cycle with rdata/err stable; next IDLE; rdata/err hold until next RESP.
REQ-032 Read latency with fl_busy=0, WAIT_CYCLES=3: handshake cycle 0, fl_rd_en cycle 1, resp_valid cycle 5.
REQ-033 req_valid outside IDLE SHALL be ignored; no request queueing.

Reset
REQ-034 rst high SHALL force state IDLE, counter 0, sticky error 0.
REQ-035 Reset outputs: req_ready 0 while rst high; resp_valid 0, resp_rdata 0, resp_err 00, all strobes 0, fl_addr 0, fl_idata 0.
REQ-036 Reset mid-operation SHALL abort without resp_valid; in-flight flash operation is not cancelled.
REQ-037 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-038 Read addr 0x005 holding 0xDEADBEEF, fl_busy=0 -> fl_rd_en cycle 1 only, resp_valid cycle 5, rdata 0xDEADBEEF, err 00.
REQ-039 Op 01 addr 0x010 data 0x12345678 on erased word -> one fl_wr_en, then one fl_rd_en addr 0x010, rdata 0x12345678, err 00.
REQ-040 Op 01 to non-zero word, flash pulses fl_error -> no verify read, err 01.
REQ-041 Op 01 where read-back returns 0x12345670 -> err 10, rdata 0x12345670.
REQ-042 Erase -> one fl_erase_en, err 00, rdata 0; subsequent read of 0x3FF returns 0.
REQ-043 fl_busy held 1 -> resp err 11 after TIMEOUT_CYCLES WAIT cycles; rst during WAIT -> no resp_valid, req_ready 1 first cycle after release.
